mux2_burst_arbiter_64: RTL

- Shares one 64-bit 2:1 select datapath between two requesters, A and B, each with a valid/ready stream.
- Round-robin arbitration with burst ownership: a granted requester keeps the path until it sends its LAST beat or hits MAX_BURST beats.
- Selected data is registered into a single-entry output stage with valid/ready toward the consumer.
- Sits in front of shared 64-bit operand/writeback paths in the LEGv8 datapath.

---
 rtl/arb_pkg.sv | 27 ++
 rtl/mux2_burst_arbiter_64_if.sv | 51 +++++
 rtl/burst_arb_fsm.sv | 109 ++++++++++
 rtl/mux2_burst_arbiter_64.sv | 78 +++++++
 4 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Purpose  : Shared types and constants for the two-requester burst arbiter
//             (FSM state encoding, source select encoding, helper function).
//  Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

  // Arbiter state; the encoding is visible on the debug OWNER port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  // Source select encoding, also driven on OUT_SRC.
  localparam logic c_SRC_A = 1'b0;
  localparam logic c_SRC_B = 1'b1;

  // The requester that is not 's'; used to hand priority over on release.
  function automatic logic other_src(input logic s);
    return ~s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux2_burst_arbiter_64_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_burst_arbiter_64_if
//  Purpose  : Bundle of the two requester streams, the consumer stream and the
//             debug owner field. 'slave' is the arbiter's view, 'master' is
//             the view of the requesters/consumer around it.
//  Revision : 1.0  initial release
// ============================================================================
interface mux2_burst_arbiter_64_if #(
  parameter int WIDTH = 64
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;

  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_src;
  logic             out_ready;

  logic [1:0]       owner;

  modport slave (
    input  a_valid, a_data, a_last,
    output a_ready,
    input  b_valid, b_data, b_last,
    output b_ready,
    output out_valid, out_data, out_last, out_src,
    input  out_ready,
    output owner
  );

  modport master (
    output a_valid, a_data, a_last,
    input  a_ready,
    output b_valid, b_data, b_last,
    input  b_ready,
    input  out_valid, out_data, out_last, out_src,
    output out_ready,
    input  owner
  );

endinterface
`default_nettype wire

// File: rtl/burst_arb_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : burst_arb_fsm
//  Purpose  : Round-robin arbiter with burst ownership. Holds state, priority
//             and beat counter; produces per-requester READY and the grant
//             (accept) strobes used by the datapath.
//  Revision : 1.0  initial release
// ============================================================================
module burst_arb_fsm
  import arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       i_a_valid,
  input  wire logic       i_a_last,
  input  wire logic       i_b_valid,
  input  wire logic       i_b_last,
  input  wire logic       i_load_ok,
  output logic            o_a_ready,
  output logic            o_b_ready,
  output logic            o_grant_a,
  output logic            o_grant_b,
  output logic [1:0]      o_owner
);

  localparam int              CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_MAX_CNT  = CNT_W'(MAX_BURST);
  // With a one-beat limit every beat is its own burst, so ownership is never taken.
  localparam logic            c_SINGLE    = (MAX_BURST == 1);

  arb_state_t       r_state, w_state_nxt;
  logic             r_prio,  w_prio_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_a_rdy, w_b_rdy;
  logic             w_grant_a, w_grant_b;
  logic             w_src, w_last;

  assign w_cnt_inc = r_cnt + c_ONE;

  // State, priority and beat-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prio  <= c_SRC_A;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Ready/grant decode and next-state logic; ready never looks at own VALID.
  always_comb begin
    w_a_rdy     = 1'b0;
    w_b_rdy     = 1'b0;
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    w_cnt_nxt   = r_cnt;

    case (r_state)
      IDLE: begin
        w_a_rdy = i_load_ok & ((r_prio == c_SRC_A) | ~i_b_valid);
        w_b_rdy = i_load_ok & ((r_prio == c_SRC_B) | ~i_a_valid);
      end
      OWN_A:   w_a_rdy = i_load_ok;
      OWN_B:   w_b_rdy = i_load_ok;
      default: ;
    endcase

    // Both READYs can be high only when at most one VALID is high, so the
    // grants are mutually exclusive by construction.
    w_grant_a = i_a_valid & w_a_rdy;
    w_grant_b = i_b_valid & w_b_rdy;
    w_src     = w_grant_b ? c_SRC_B : c_SRC_A;
    w_last    = w_grant_b ? i_b_last : i_a_last;

    if (w_grant_a | w_grant_b) begin
      if (r_state == IDLE) begin
        if (w_last | c_SINGLE) begin
          w_prio_nxt = other_src(w_src);
        end else begin
          w_state_nxt = (w_src == c_SRC_B) ? OWN_B : OWN_A;
          w_cnt_nxt   = c_ONE;
        end
      end else if (w_last | (w_cnt_inc == c_MAX_CNT)) begin
        // End of burst or forced release: the other side gets first pick.
        w_state_nxt = IDLE;
        w_prio_nxt  = other_src(w_src);
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    end
  end

  // READY is held low for the whole time reset is asserted.
  assign o_a_ready = w_a_rdy & rst_n;
  assign o_b_ready = w_b_rdy & rst_n;
  assign o_grant_a = w_grant_a & rst_n;
  assign o_grant_b = w_grant_b & rst_n;
  assign o_owner   = r_state;

endmodule
`default_nettype wire

// File: rtl/mux2_burst_arbiter_64.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_burst_arbiter_64
//  Purpose  : Shares one 2:1 data select between requesters A and B under a
//             burst-owning round-robin arbiter, with a single-entry registered
//             output stage toward the consumer.
//  Revision : 1.0  initial release
// ============================================================================
module mux2_burst_arbiter_64
  import arb_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  mux2_burst_arbiter_64_if.slave bus
);

  logic             w_load_ok;
  logic             w_grant_a, w_grant_b;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_last;
  logic             r_src;

  // The output stage can take a new beat when empty or being drained now.
  assign w_load_ok = ~r_valid | bus.out_ready;

  burst_arb_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_a_valid (bus.a_valid),
    .i_a_last  (bus.a_last),
    .i_b_valid (bus.b_valid),
    .i_b_last  (bus.b_last),
    .i_load_ok (w_load_ok),
    .o_a_ready (bus.a_ready),
    .o_b_ready (bus.b_ready),
    .o_grant_a (w_grant_a),
    .o_grant_b (w_grant_b),
    .o_owner   (bus.owner)
  );

  assign w_sel_data = w_grant_b ? bus.b_data : bus.a_data;
  assign w_sel_last = w_grant_b ? bus.b_last : bus.a_last;

  // Output register: load the granted beat, or empty out when drained idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_src   <= c_SRC_A;
    end else if (w_load_ok) begin
      if (w_grant_a | w_grant_b) begin
        r_valid <= 1'b1;
        r_data  <= w_sel_data;
        r_last  <= w_sel_last;
        r_src   <= w_grant_b ? c_SRC_B : c_SRC_A;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign bus.out_src   = r_src;

endmodule
`default_nettype wire
